// File: rtl/bitonic_pkg.sv
// bitonic_pkg: shared helpers for the pipelined bitonic sorter.
//   clog2        - ceiling log2 (constant-evaluable)
//   num_stages   - compare-exchange columns for an N-key network
//   stage_phase  - merge phase p (1-based) of a 0-based column index
//   stage_sub    - sub-step q (1-based) within that phase
//   stage_dist   - partner distance 2^(p-q) of a column
//   stage_dir    - 1 when the cell at lower index i sorts descending (before desc XOR)
package bitonic_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int num_stages(input int n);
        int l;
        l = clog2(n);
        return l * (l + 1) / 2;
    endfunction

    function automatic int stage_phase(input int s);
        int p, rem;
        p   = 1;
        rem = s;
        while (rem >= p) begin
            rem -= p;
            p++;
        end
        return p;
    endfunction

    function automatic int stage_sub(input int s);
        int p, rem;
        p   = 1;
        rem = s;
        while (rem >= p) begin
            rem -= p;
            p++;
        end
        return rem + 1;
    endfunction

    function automatic int stage_dist(input int s);
        return 1 << (stage_phase(s) - stage_sub(s));
    endfunction

    // Blocks of 2^p keys alternate direction in phase p; bit p of i selects it.
    function automatic logic stage_dir(input int s, input int i);
        return ((i >> stage_phase(s)) & 1) != 0;
    endfunction

endpackage

// File: rtl/bitonic_cas.sv
// bitonic_cas: combinational compare-exchange cell.
//   a_key/b_key  keys at the lower/higher network position
//   dir          0: lo gets the smaller, 1: lo gets the larger
//   lo_key/hi_key results for the lower/higher position
//   With BITONIC_SORT_IDX_EN, a_tag/b_tag ride along and break ties, so the
//   cell orders the composite {key, tag}.
module bitonic_cas #(
    parameter int W  = 8
`ifdef BITONIC_SORT_IDX_EN
   ,parameter int TW = 4
`endif
) (
    input  logic [W-1:0]  a_key,
    input  logic [W-1:0]  b_key,
`ifdef BITONIC_SORT_IDX_EN
    input  logic [TW-1:0] a_tag,
    input  logic [TW-1:0] b_tag,
    output logic [TW-1:0] lo_tag,
    output logic [TW-1:0] hi_tag,
`endif
    input  logic          dir,
    output logic [W-1:0]  lo_key,
    output logic [W-1:0]  hi_key
);
    logic swap;

`ifdef BITONIC_SORT_IDX_EN
    logic [W+TW-1:0] a_c, b_c;
    assign a_c    = {a_key, a_tag};
    assign b_c    = {b_key, b_tag};
    assign swap   = dir ? (a_c < b_c) : (a_c > b_c);
    assign lo_tag = swap ? b_tag : a_tag;
    assign hi_tag = swap ? a_tag : b_tag;
`else
    assign swap   = dir ? (a_key < b_key) : (a_key > b_key);
`endif

    assign lo_key = swap ? b_key : a_key;
    assign hi_key = swap ? a_key : b_key;
endmodule

// File: rtl/bitonic_sort_pipe.sv
// bitonic_sort_pipe: fully pipelined bitonic sorting network, N keys of W bits.
//   clk/rst      rising-edge clock, async active-high reset
//   flush        sync: clears every in-flight valid bit
//   in_valid/in_ready/in_desc/in_data   input stream (key i at [i*W +: W])
//   out_valid/out_ready/out_data        sorted output (position j at [j*W +: W])
//   out_idx      original index per output position (BITONIC_SORT_IDX_EN only)
// Optional feature macro: BITONIC_SORT_IDX_EN (stable sort with index tags).
// The whole pipe advances together; a stall freezes every rank.
module bitonic_sort_pipe
    import bitonic_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_desc,
    input  logic [N*W-1:0]             in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N*W-1:0]             out_data
`ifdef BITONIC_SORT_IDX_EN
   ,output logic [N*clog2(N)-1:0]      out_idx
`endif
);
    localparam int S = num_stages(N);

    logic         adv;
    logic [S:0]   vld_pipe;            // [0] is the live input, [s+1] is rank s
    logic [W-1:0] key_d [S][N];        // column inputs
    logic [W-1:0] key_c [S][N];        // column outputs (pre-register)
    logic [W-1:0] key_q [S][N];        // register ranks
    logic         desc_d [S];
    logic         desc_q [S];

`ifdef BITONIC_SORT_IDX_EN
    localparam int TW = clog2(N);
    logic [TW-1:0] tag_d [S][N];
    logic [TW-1:0] tag_c [S][N];
    logic [TW-1:0] tag_q [S][N];
`endif

    assign adv         = out_ready | ~out_valid;
    assign in_ready    = adv;
    assign vld_pipe[0] = in_valid;
    assign out_valid   = vld_pipe[S];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        vld_pipe[S:1] <= '0;
        else if (flush) vld_pipe[S:1] <= '0;
        else if (adv)   vld_pipe[S:1] <= vld_pipe[S-1:0];
    end

    for (genvar s = 0; s < S; s++) begin : g_col
        localparam int D = stage_dist(s);

        if (s == 0) begin : g_src0
            for (genvar i = 0; i < N; i++) begin : g_k
                assign key_d[0][i] = in_data[i*W +: W];
`ifdef BITONIC_SORT_IDX_EN
                // Descending vectors carry inverted tags so a plain {key,tag}
                // compare keeps equal keys in input order; undone at the output.
                assign tag_d[0][i] = in_desc ? ~TW'(i) : TW'(i);
`endif
            end
            assign desc_d[0] = in_desc;
        end else begin : g_srcn
            assign key_d[s]  = key_q[s-1];
            assign desc_d[s] = desc_q[s-1];
`ifdef BITONIC_SORT_IDX_EN
            assign tag_d[s]  = tag_q[s-1];
`endif
        end

        for (genvar i = 0; i < N; i++) begin : g_cell
            if ((i & D) == 0) begin : g_cas
                bitonic_cas #(
                    .W  (W)
`ifdef BITONIC_SORT_IDX_EN
                   ,.TW (TW)
`endif
                ) u_cas (
                    .a_key  (key_d[s][i]),
                    .b_key  (key_d[s][i+D]),
`ifdef BITONIC_SORT_IDX_EN
                    .a_tag  (tag_d[s][i]),
                    .b_tag  (tag_d[s][i+D]),
                    .lo_tag (tag_c[s][i]),
                    .hi_tag (tag_c[s][i+D]),
`endif
                    .dir    (stage_dir(s, i) ^ desc_d[s]),
                    .lo_key (key_c[s][i]),
                    .hi_key (key_c[s][i+D])
                );
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                desc_q[s] <= 1'b0;
                for (int i = 0; i < N; i++) begin
                    key_q[s][i] <= '0;
`ifdef BITONIC_SORT_IDX_EN
                    tag_q[s][i] <= '0;
`endif
                end
            end else if (adv) begin
                desc_q[s] <= desc_d[s];
                for (int i = 0; i < N; i++) begin
                    key_q[s][i] <= key_c[s][i];
`ifdef BITONIC_SORT_IDX_EN
                    tag_q[s][i] <= tag_c[s][i];
`endif
                end
            end
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_out
        assign out_data[j*W +: W] = key_q[S-1][j];
`ifdef BITONIC_SORT_IDX_EN
        assign out_idx[j*TW +: TW] = desc_q[S-1] ? ~tag_q[S-1][j] : tag_q[S-1][j];
`endif
    end
endmodule
